// File: rtl/kyogenrv_loader_pkg.sv
// kyogenrv_loader_pkg: shared types and constants for the UART instruction loader.
// Defining LOADER_PARITY_EN adds the PARITY receive state (even parity after the data bits).
package kyogenrv_loader_pkg;
  localparam int DATA_BITS = 8;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef LOADER_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronizes rxd and receives 8N1 bytes (8E1 when LOADER_PARITY_EN is defined).
// byte_valid_o and err_o are single-cycle strobes raised in the cycle the stop/parity bit is sampled.
module uart_rx_core
  import kyogenrv_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_byte_o,
  output logic                 byte_valid_o,
  output logic                 err_o,
  output logic                 idle_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_e state_q, state_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic par_bad_q, par_bad_d;
  logic rxd_s, tick, half;
  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detection
  assign rxd_s = sync_q[1];
  assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign half = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign rx_byte_o = shift_q;
  assign idle_o = state_q == IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_bad_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rxd_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_bad_q <= par_bad_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_bad_d = par_bad_q;
    byte_valid_o = 1'b0;
    err_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        par_bad_d = 1'b0;
        if (sync_q[2] && !rxd_s) state_d = START;
      end
      START: if (half) begin
        cnt_d = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = '0;
        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
`ifdef LOADER_PARITY_EN
        if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef LOADER_PARITY_EN
      PARITY: if (tick) begin
        cnt_d = '0;
        par_bad_d = rxd_s != ^shift_q;
        err_o = par_bad_d;
        state_d = STOP;
      end
`endif
      // a parity failure already reported its error; the stop bit then only steers the FSM
      STOP: if (tick) begin
        byte_valid_o = rxd_s && !par_bad_q;
        err_o = !rxd_s && !par_bad_q;
        state_d = rxd_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_inst_loader.sv
// uart_inst_loader: assembles four little-endian UART bytes into 32-bit instruction words.
// Define LOADER_PARITY_EN to expect an even-parity bit after each byte's data bits.
module uart_inst_loader
  import kyogenrv_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic [31:0] inst_data,
  output logic        inst_valid,
  output logic [15:0] inst_count,
  output logic        frame_err
);
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TMO + 1);
  logic [DATA_BITS-1:0] rx_byte;
  logic byte_valid, err, idle, timeout;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0] asm_q, asm_d, data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic valid_q, valid_d, ferr_q;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rxd_i       (rxd),
    .rx_byte_o   (rx_byte),
    .byte_valid_o(byte_valid),
    .err_o       (err),
    .idle_o      (idle)
  );
  assign timeout = tmo_q == TW'(TMO - 1);
  assign inst_data = data_q;
  assign inst_valid = valid_q;
  assign inst_count = cnt_q;
  assign frame_err = ferr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx_q <= '0;
      asm_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      valid_q <= valid_d;
      ferr_q <= err;
    end
  // the idle window only runs while a partial word is pending
  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    data_d = data_q;
    valid_d = byte_valid && &idx_q;
    cnt_d = cnt_q + 16'(valid_d);
    tmo_d = (idle && idx_q != '0 && !timeout) ? tmo_q + 1'b1 : '0;
    if (timeout || err) idx_d = '0;
    if (byte_valid) begin
      asm_d[DATA_BITS*idx_q +: DATA_BITS] = rx_byte;
      idx_d = idx_q + 1'b1;
      if (&idx_q) data_d = {rx_byte, asm_q[23:0]};
    end
  end
endmodule

// File: tb/tb_uart_inst_loader.sv
// tb_uart_inst_loader: table-driven and randomized checks of the UART instruction loader.
module tb_uart_inst_loader;
  localparam int CPB = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic [31:0] inst_data;
  logic inst_valid;
  logic [15:0] inst_count;
  logic frame_err;
  int vectors = 0;
  int miscompares = 0;
  int valids = 0;
  int errs = 0;

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    int          idle;
    logic [31:0] data;
    int          cnt;
    int          nv;
    int          ne;
  } vec_t;
  vec_t tbl[23];

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .inst_data (inst_data),
    .inst_valid(inst_valid),
    .inst_count(inst_count),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // every high cycle counts, so a stretched pulse shows up as an extra pulse
  always @(posedge clk) begin
    #1;
    if (inst_valid === 1'b1) valids <= valids + 1;
    if (frame_err === 1'b1) errs <= errs + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef LOADER_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
    repeat (idle_bits) send_bit(1'b1);
  endtask

`ifdef LOADER_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int bv, be, m_cnt, m_nv, m_ne, gap;
    logic [31:0] m_data;
    logic [7:0] q[$];
    logic [7:0] d;
    logic stop;
    tbl[0]  = '{8'h13, 1'b1, 1,  32'h00000000, 0, 0, 0};
    tbl[1]  = '{8'h05, 1'b1, 1,  32'h00000000, 0, 0, 0};
    tbl[2]  = '{8'h10, 1'b1, 1,  32'h00000000, 0, 0, 0};
    tbl[3]  = '{8'h00, 1'b1, 1,  32'h00100513, 1, 1, 0};
    tbl[4]  = '{8'hEF, 1'b1, 0,  32'h00100513, 1, 1, 0};
    tbl[5]  = '{8'hBE, 1'b1, 0,  32'h00100513, 1, 1, 0};
    tbl[6]  = '{8'hAD, 1'b1, 0,  32'h00100513, 1, 1, 0};
    tbl[7]  = '{8'hDE, 1'b1, 0,  32'hDEADBEEF, 2, 2, 0};
    tbl[8]  = '{8'hEF, 1'b1, 0,  32'hDEADBEEF, 2, 2, 0};
    tbl[9]  = '{8'hBE, 1'b1, 0,  32'hDEADBEEF, 2, 2, 0};
    tbl[10] = '{8'hAD, 1'b1, 0,  32'hDEADBEEF, 2, 2, 0};
    tbl[11] = '{8'hDE, 1'b1, 1,  32'hDEADBEEF, 3, 3, 0};
    tbl[12] = '{8'h55, 1'b0, 1,  32'hDEADBEEF, 3, 3, 1};
    tbl[13] = '{8'h01, 1'b1, 0,  32'hDEADBEEF, 3, 3, 1};
    tbl[14] = '{8'h02, 1'b1, 0,  32'hDEADBEEF, 3, 3, 1};
    tbl[15] = '{8'h03, 1'b1, 0,  32'hDEADBEEF, 3, 3, 1};
    tbl[16] = '{8'h04, 1'b1, 1,  32'h04030201, 4, 4, 1};
    tbl[17] = '{8'h11, 1'b1, 0,  32'h04030201, 4, 4, 1};
    tbl[18] = '{8'h22, 1'b1, 40, 32'h04030201, 4, 4, 1};
    tbl[19] = '{8'h78, 1'b1, 0,  32'h04030201, 4, 4, 1};
    tbl[20] = '{8'h56, 1'b1, 0,  32'h04030201, 4, 4, 1};
    tbl[21] = '{8'h34, 1'b1, 0,  32'h04030201, 4, 4, 1};
    tbl[22] = '{8'h12, 1'b1, 1,  32'h12345678, 5, 5, 1};

    repeat (3) @(negedge clk);
    check("reset inst_data", inst_data, 32'h0);
    check("reset inst_valid", {31'h0, inst_valid}, 32'h0);
    check("reset inst_count", {16'h0, inst_count}, 32'h0);
    check("reset frame_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch valid pulses", valids, 0);
    check("glitch err pulses", errs, 0);
    check("glitch inst_count", {16'h0, inst_count}, 32'h0);

    bv = valids;
    be = errs;
    for (int i = 0; i < 23; i++) begin
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].idle);
      check($sformatf("tbl[%0d] inst_data", i), inst_data, tbl[i].data);
      check($sformatf("tbl[%0d] inst_count", i), {16'h0, inst_count}, tbl[i].cnt);
      check($sformatf("tbl[%0d] valid pulses", i), valids - bv, tbl[i].nv);
      check($sformatf("tbl[%0d] err pulses", i), errs - be, tbl[i].ne);
    end

    send_frame(8'hAA, 1'b1, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    check("midreset inst_data", inst_data, 32'h0);
    check("midreset inst_valid", {31'h0, inst_valid}, 32'h0);
    check("midreset inst_count", {16'h0, inst_count}, 32'h0);
    check("midreset frame_err", {31'h0, frame_err}, 32'h0);
    rxd = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    bv = valids;
    be = errs;
    send_frame(8'h44, 1'b1, 1);
    send_frame(8'h33, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    send_frame(8'h11, 1'b1, 1);
    check("postreset inst_data", inst_data, 32'h11223344);
    check("postreset inst_count", {16'h0, inst_count}, 32'h1);
    check("postreset valid pulses", valids - bv, 1);
    check("postreset err pulses", errs - be, 0);

`ifdef LOADER_PARITY_EN
    bv = valids;
    be = errs;
    send_par_frame(8'hA5, 1'b1);
    check("parity bad err pulses", errs - be, 1);
    check("parity bad valid pulses", valids - bv, 0);
    send_par_frame(8'hA5, 1'b0);
    send_frame(8'hB6, 1'b1, 1);
    send_frame(8'hC7, 1'b1, 1);
    send_frame(8'hD8, 1'b1, 1);
    check("parity inst_data", inst_data, 32'hD8C7B6A5);
    check("parity inst_count", {16'h0, inst_count}, 32'h2);
    check("parity err pulses", errs - be, 1);
`endif

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    bv = valids;
    be = errs;
    m_data = 32'h0;
    m_cnt = 0;
    m_nv = 0;
    m_ne = 0;
    q.delete();
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      gap = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(stop ? 0 : 1, 2));
      send_frame(d, stop, gap);
      if (!stop) begin
        m_ne++;
        q.delete();
      end else begin
        q.push_back(d);
        if (q.size() == 4) begin
          m_data = {q[3], q[2], q[1], q[0]};
          m_cnt = (m_cnt + 1) % 65536;
          m_nv++;
          q.delete();
        end
      end
      if (gap >= 32) q.delete();
      check($sformatf("rnd[%0d] inst_data", n), inst_data, m_data);
      check($sformatf("rnd[%0d] inst_count", n), {16'h0, inst_count}, m_cnt);
      check($sformatf("rnd[%0d] valid pulses", n), valids - bv, m_nv);
      check($sformatf("rnd[%0d] err pulses", n), errs - be, m_ne);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
